// File: rtl/audio_pkg.sv
// Shared constants and types for the synth-to-PWM audio sample path.
package audio_pkg;

  localparam int unsigned CodeWidth = 10;

  typedef logic [CodeWidth-1:0] sample_code_t;

  // Midscale is silence for an unsigned duty code.
  localparam sample_code_t MidscaleCode = CodeWidth'(1) << (CodeWidth - 1);

  function automatic int unsigned midscale(input int unsigned width);
    return 32'd1 << (width - 1);
  endfunction

endpackage

// File: rtl/sample_pwm_dac_if.sv
// Valid/ready sample channel from the synth into the PWM DAC.
interface sample_pwm_dac_if #(
  parameter int unsigned CODE_WIDTH = audio_pkg::CodeWidth
);

  logic                  synth_valid;
  logic                  synth_ready;
  logic [CODE_WIDTH-1:0] scaled_synth_code;

  modport master (
    output synth_valid,
    output scaled_synth_code,
    input  synth_ready
  );

  modport slave (
    input  synth_valid,
    input  scaled_synth_code,
    output synth_ready
  );

endinterface

// File: rtl/pwm_dac.sv
// Free-running PWM frame counter, duty comparator and registered output bit.
module pwm_dac #(
  parameter int unsigned CODE_WIDTH = audio_pkg::CodeWidth
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [CODE_WIDTH-1:0] code,
  output logic                  boundary,
  output logic                  pwm_out
);

  logic [CODE_WIDTH-1:0] cnt_q, cnt_d;
  logic                  pwm_q, pwm_d;

  always_comb begin
    cnt_d = cnt_q + 1'b1;
    pwm_d = (cnt_q < code);
  end

  // Last cycle of the frame; the next code must be loaded on this edge.
  assign boundary = &cnt_q;
  assign pwm_out  = pwm_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
      pwm_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      pwm_q <= pwm_d;
    end
  end

endmodule

// File: rtl/sample_pwm_dac.sv
// Buffers synth codes and hands exactly one to the PWM stage per frame, flagging underruns.
module sample_pwm_dac
  import audio_pkg::*;
#(
  parameter int unsigned           CODE_WIDTH         = CodeWidth,
  parameter int unsigned           BUF_DEPTH          = 2,
  parameter int unsigned           UNDERRUN_CNT_WIDTH = 16,
  parameter logic [CODE_WIDTH-1:0] RESET_CODE         = CODE_WIDTH'(midscale(CODE_WIDTH))
) (
  input  logic                          clk,
  input  logic                          rst,
  sample_pwm_dac_if.slave               synth,
  output logic                          pwm_out,
  output logic                          frame_start,
  output logic                          underrun,
  output logic [UNDERRUN_CNT_WIDTH-1:0] underrun_count
);

  localparam int unsigned PtrW = $clog2(BUF_DEPTH);
  localparam int unsigned OccW = PtrW + 1;

  logic [CODE_WIDTH-1:0]         buf_q [BUF_DEPTH];
  logic [PtrW-1:0]               rd_ptr_q, rd_ptr_d;
  logic [PtrW-1:0]               wr_ptr_q, wr_ptr_d;
  logic [OccW-1:0]               occ_q, occ_d;
  logic [CODE_WIDTH-1:0]         cur_code_q, cur_code_d;
  logic                          frame_start_q, underrun_q;
  logic [UNDERRUN_CNT_WIDTH-1:0] urun_cnt_q, urun_cnt_d;

  logic full, empty, push, pop, boundary;

  // Ready depends on registered occupancy only, so the synth may hold valid high.
  assign full              = (occ_q == OccW'(BUF_DEPTH));
  assign empty             = (occ_q == '0);
  assign synth.synth_ready = ~full;
  assign push              = synth.synth_valid & ~full;
  // Pop uses pre-push occupancy, so a code arriving on the boundary is never bypassed.
  assign pop               = boundary & ~empty;

  always_comb begin
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    occ_d      = occ_q;
    cur_code_d = cur_code_q;
    urun_cnt_d = urun_cnt_q;

    if (push) begin
      wr_ptr_d = wr_ptr_q + 1'b1;
    end
    if (pop) begin
      rd_ptr_d   = rd_ptr_q + 1'b1;
      cur_code_d = buf_q[rd_ptr_q];
    end

    case ({push, pop})
      2'b10:   occ_d = occ_q + 1'b1;
      2'b01:   occ_d = occ_q - 1'b1;
      default: occ_d = occ_q;
    endcase

    if (boundary && empty && !(&urun_cnt_q)) begin
      urun_cnt_d = urun_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr_q      <= '0;
      wr_ptr_q      <= '0;
      occ_q         <= '0;
      cur_code_q    <= RESET_CODE;
      frame_start_q <= 1'b0;
      underrun_q    <= 1'b0;
      urun_cnt_q    <= '0;
    end else begin
      rd_ptr_q      <= rd_ptr_d;
      wr_ptr_q      <= wr_ptr_d;
      occ_q         <= occ_d;
      cur_code_q    <= cur_code_d;
      frame_start_q <= boundary;
      underrun_q    <= boundary & empty;
      urun_cnt_q    <= urun_cnt_d;
    end
  end

  // Storage needs no reset: the cleared pointers discard any stale entries.
  always_ff @(posedge clk) begin
    if (push) begin
      buf_q[wr_ptr_q] <= synth.scaled_synth_code;
    end
  end

  pwm_dac #(
    .CODE_WIDTH (CODE_WIDTH)
  ) u_pwm_dac (
    .clk      (clk),
    .rst      (rst),
    .code     (cur_code_q),
    .boundary (boundary),
    .pwm_out  (pwm_out)
  );

  assign frame_start    = frame_start_q;
  assign underrun       = underrun_q;
  assign underrun_count = urun_cnt_q;

endmodule

// File: tb/tb_sample_pwm_dac.sv
// Directed bench for sample_pwm_dac: idle underruns, back-to-back codes, boundary races, reset.
module tb_sample_pwm_dac;
  import audio_pkg::*;

  localparam int unsigned FrameLen = 1 << CodeWidth;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        pwm_out, frame_start, underrun;
  logic [15:0] underrun_count;
  logic        pwm_out_s, frame_start_s, underrun_s;
  logic [1:0]  underrun_count_s;

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;
  int unsigned highs;
  int unsigned urun_mid;

  sample_pwm_dac_if #(.CODE_WIDTH(CodeWidth)) bus ();
  sample_pwm_dac_if #(.CODE_WIDTH(CodeWidth)) bus_s ();

  sample_pwm_dac #(
    .CODE_WIDTH         (CodeWidth),
    .BUF_DEPTH          (2),
    .UNDERRUN_CNT_WIDTH (16),
    .RESET_CODE         (MidscaleCode)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .synth          (bus),
    .pwm_out        (pwm_out),
    .frame_start    (frame_start),
    .underrun       (underrun),
    .underrun_count (underrun_count)
  );

  // Narrow counter copy, left idle, to exercise saturation.
  sample_pwm_dac #(
    .CODE_WIDTH         (CodeWidth),
    .BUF_DEPTH          (2),
    .UNDERRUN_CNT_WIDTH (2),
    .RESET_CODE         (MidscaleCode)
  ) dut_sat (
    .clk            (clk),
    .rst            (rst),
    .synth          (bus_s),
    .pwm_out        (pwm_out_s),
    .frame_start    (frame_start_s),
    .underrun       (underrun_s),
    .underrun_count (underrun_count_s)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input int unsigned got, input int unsigned exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
  endtask

  task automatic wait_frame();
    int unsigned n = 0;
    while (!frame_start && n < 2 * FrameLen) begin
      @(negedge clk);
      n++;
    end
    if (!frame_start) check_val("frame_start_timeout", 0, 1);
  endtask

  // Counts pwm_out highs over one frame; urun_o counts underrun pulses strictly inside it.
  task automatic measure(output int unsigned highs_o, output int unsigned urun_o);
    highs_o = 0;
    urun_o  = 0;
    for (int i = 0; i < FrameLen; i++) begin
      @(negedge clk);
      highs_o += 32'(pwm_out);
      if (i < FrameLen - 1) urun_o += 32'(underrun);
    end
  endtask

  task automatic push(input int unsigned code);
    bus.synth_valid       = 1'b1;
    bus.scaled_synth_code = sample_code_t'(code);
    @(negedge clk);
    bus.synth_valid = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check_val({tag, "_pwm_out"}, 32'(pwm_out), 0);
    check_val({tag, "_frame_start"}, 32'(frame_start), 0);
    check_val({tag, "_underrun"}, 32'(underrun), 0);
    check_val({tag, "_underrun_count"}, 32'(underrun_count), 0);
    check_val({tag, "_ready"}, 32'(bus.synth_ready), 1);
    check_val({tag, "_sat_count"}, 32'(underrun_count_s), 0);
  endtask

  initial begin
    bus.synth_valid         = 1'b0;
    bus.scaled_synth_code   = '0;
    bus_s.synth_valid       = 1'b0;
    bus_s.scaled_synth_code = '0;

    repeat (3) @(negedge clk);
    check_reset_outputs("rst");
    rst = 1'b0;
    check_val("ready_first_cycle", 32'(bus.synth_ready), 1);

    // Idle: midscale plays, every boundary underruns.
    measure(highs, urun_mid);
    check_val("idle_f0_highs", highs, 512);
    check_val("idle_f0_no_mid_underrun", urun_mid, 0);
    wait_frame();
    check_val("idle_b1_underrun", 32'(underrun), 1);
    check_val("idle_b1_count", 32'(underrun_count), 1);
    measure(highs, urun_mid);
    check_val("idle_f1_highs", highs, 512);
    wait_frame();
    check_val("idle_b2_count", 32'(underrun_count), 2);
    check_val("sat_b2_count", 32'(underrun_count_s), 2);
    measure(highs, urun_mid);
    check_val("idle_f2_highs", highs, 512);
    wait_frame();
    check_val("idle_b3_underrun", 32'(underrun), 1);
    check_val("idle_b3_count", 32'(underrun_count), 3);

    // Back-to-back 0, 1023, 100: third waits for space.
    push(0);
    push(1023);
    bus.synth_valid       = 1'b1;
    bus.scaled_synth_code = sample_code_t'(100);
    check_val("b2b_ready_full", 32'(bus.synth_ready), 0);
    wait_frame();
    check_val("b2b_b4_no_underrun", 32'(underrun), 0);
    check_val("b2b_ready_after_pop", 32'(bus.synth_ready), 1);
    measure(highs, urun_mid);
    bus.synth_valid = 1'b0;
    check_val("b2b_code0_highs", highs, 0);
    wait_frame();
    check_val("b2b_b5_no_underrun", 32'(underrun), 0);
    check_val("sat_b5_count", 32'(underrun_count_s), 3);
    measure(highs, urun_mid);
    check_val("b2b_code1023_highs", highs, 1023);
    wait_frame();
    check_val("b2b_b6_no_underrun", 32'(underrun), 0);
    measure(highs, urun_mid);
    check_val("b2b_code100_highs", highs, 100);
    wait_frame();
    check_val("b2b_drained_underrun", 32'(underrun), 1);

    // Push coincident with pop at occupancy 1.
    push(200);
    repeat (FrameLen - 2) @(negedge clk);
    bus.synth_valid       = 1'b1;
    bus.scaled_synth_code = sample_code_t'(300);
    check_val("coinc_ready", 32'(bus.synth_ready), 1);
    @(negedge clk);
    bus.synth_valid = 1'b0;
    check_val("coinc_frame_start", 32'(frame_start), 1);
    check_val("coinc_no_underrun", 32'(underrun), 0);
    check_val("coinc_ready_after", 32'(bus.synth_ready), 1);
    measure(highs, urun_mid);
    check_val("coinc_old_code_highs", highs, 200);
    wait_frame();
    check_val("coinc_next_no_underrun", 32'(underrun), 0);
    measure(highs, urun_mid);
    check_val("coinc_new_code_highs", highs, 300);
    wait_frame();
    check_val("coinc_then_empty_underrun", 32'(underrun), 1);

    // Push into an empty buffer on the boundary cycle: no bypass.
    repeat (FrameLen - 1) @(negedge clk);
    bus.synth_valid       = 1'b1;
    bus.scaled_synth_code = sample_code_t'(50);
    @(negedge clk);
    bus.synth_valid = 1'b0;
    check_val("edge_push_frame_start", 32'(frame_start), 1);
    check_val("edge_push_underrun", 32'(underrun), 1);
    measure(highs, urun_mid);
    check_val("edge_push_repeat_highs", highs, 300);
    wait_frame();
    check_val("edge_push_next_no_underrun", 32'(underrun), 0);
    measure(highs, urun_mid);
    check_val("edge_push_new_highs", highs, 50);
    wait_frame();

    // Reset at cnt=300 with two codes buffered.
    push(700);
    push(900);
    check_val("rst_mid_ready_full", 32'(bus.synth_ready), 0);
    repeat (298) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check_reset_outputs("rst_mid");
    rst = 1'b0;
    measure(highs, urun_mid);
    check_val("rst_mid_f0_highs", highs, 512);
    wait_frame();
    check_val("rst_mid_b1_underrun", 32'(underrun), 1);
    check_val("rst_mid_b1_count", 32'(underrun_count), 1);
    measure(highs, urun_mid);
    check_val("rst_mid_f1_highs", highs, 512);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
